fifo_write_arbiter: RTL and testbench

Round-robin, packet-aware arbiter that shares the single write port of an output-port FIFO between `N_REQ` router input requesters. It grants one requester at a time and holds the grant until that requester's packet ends, with `last` marking the final beat. It gates each write beat against the FIFO full flag and drives `winc`/`wdata` into the FIFO write side. A beat counter releases a requester that exceeds `MAX_BEATS` and raises an error pulse.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 28 ++
 rtl/fifo_write_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  // Beat counter must be able to hold MAX_BEATS itself.
  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic             any
);

  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] sel;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      hi_mask[i] = (PTR_W'(i) >= ptr);
    end
  end

  // Prefer requests at or above ptr; fall back to the full set for wrap-around.
  assign masked = req & hi_mask;
  assign sel    = (|masked) ? masked : req;
  assign pick   = sel & (-sel);
  assign any    = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-aware round-robin arbiter sharing one FIFO write port among N_REQ requesters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DATA_W-1:0]       wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    pkt_err
);

  localparam int                PTR_W    = $clog2(N_REQ);
  localparam int                CNT_W    = beat_cnt_w(MAX_BEATS);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BEATS);

  state_e           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt, pick;
  logic [PTR_W-1:0] ptr, ptr_nxt, g_idx, ptr_after;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             any, accept, last, err_nxt;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // gnt is zero outside XFER, so the write side is naturally quiet in IDLE and during reset.
  assign req_ready = gnt & req_valid & {N_REQ{~wfull}};
  assign accept    = |req_ready;
  assign winc      = accept;
  assign last      = |(gnt & req_last);
  assign busy      = (state == XFER);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign ptr_after = (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);

  always_comb begin
    wdata = '0;
    g_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        wdata = req_data[i*DATA_W +: DATA_W];
        g_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (any) begin
          gnt_nxt   = pick;
          cnt_nxt   = '0;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          cnt_nxt = cnt_inc;
          if (last || cnt_inc == CNT_MAX) begin
            err_nxt   = ~last;
            ptr_nxt   = ptr_after;
            gnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      pkt_err <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      pkt_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: per-cycle vector table plus a write-data scoreboard queue.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_last, req_ready, gnt;
  logic [N*DW-1:0] req_data;
  logic          wfull, winc, busy, pkt_err;
  logic [DW-1:0] wdata;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt       (gnt),
    .busy      (busy),
    .pkt_err   (pkt_err)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       winc;
    logic       err;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         split;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic f,
                     input logic [3:0] d, input logic [3:0] g, input logic w, input logic e);
    vec_t x;
    x.valid = v; x.last = l; x.full = f; x.d = d;
    x.gnt = g; x.winc = w; x.err = e;
    vecs.push_back(x);
  endtask

  // Port i carries {9+i, beat nibble}, so requester 1 sends 0xA1, 0xA2, ...
  function automatic logic [7:0] beat_data(input int port, input logic [3:0] d);
    return {4'h9 + 4'(port), d};
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [3:0] d);
    req_valid = v;
    req_last  = l;
    wfull     = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = beat_data(i, d);
  endtask

  task automatic apply(input vec_t x, input int n);
    @(negedge clk);
    drive(x.valid, x.last, x.full, x.d);
    if (x.winc) sb.push_back(beat_data(idx_of(x.gnt), x.d));
    #1;
    check($sformatf("gnt[%0d]", n),   32'(gnt),       32'(x.gnt));
    check($sformatf("winc[%0d]", n),  32'(winc),      32'(x.winc));
    check($sformatf("ready[%0d]", n), 32'(req_ready), 32'(x.winc ? x.gnt : 4'b0));
    check($sformatf("busy[%0d]", n),  32'(busy),      32'(|x.gnt));
    check($sformatf("err[%0d]", n),   32'(pkt_err),   32'(x.err));
    if (winc) begin
      if (sb.size() == 0) check($sformatf("sb_unexpected_write[%0d]", n), 32'(winc), 32'(0));
      else                check($sformatf("wdata[%0d]", n), 32'(wdata), 32'(sb.pop_front()));
    end
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // All four requesting, 2-beat packets from ptr=0: grants 0,1,2,3,0 with an idle gap each.
    for (int k = 0; k < 5; k++) begin
      add(4'hF, 4'h0, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
      add(4'hF, 4'h0, 1'b0, 4'h1, order[k], 1'b1, 1'b0);
      add(4'hF, 4'hF, 1'b0, 4'h2, order[k], 1'b1, 1'b0);
    end
    add(4'h0, 4'h0, 1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requester 1 alone, 3 beats A1..A3 (ptr=1 afterwards becomes 2).
    add(4'b0010, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b0010, 4'h0,    1'b0, 4'h1, 4'b0010, 1'b1, 1'b0);
    add(4'b0010, 4'h0,    1'b0, 4'h2, 4'b0010, 1'b1, 1'b0);
    add(4'b0010, 4'b0010, 1'b0, 4'h3, 4'b0010, 1'b1, 1'b0);
    add(4'b0000, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requesters 0,1,2: with ptr=2 requester 2 must win.
    add(4'b0111, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b0111, 4'b0100, 1'b0, 4'h1, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requester 0, 4 beats with wfull for 5 cycles after beat 1; count must not advance.
    add(4'b0001, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b0001, 4'h0,    1'b0, 4'h1, 4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) add(4'b0001, 4'h0, 1'b1, 4'h2, 4'b0001, 1'b0, 1'b0);
    add(4'b0001, 4'h0,    1'b0, 4'h2, 4'b0001, 1'b1, 1'b0);
    add(4'b0001, 4'h0,    1'b0, 4'h3, 4'b0001, 1'b1, 1'b0);
    add(4'b0001, 4'b0001, 1'b0, 4'h4, 4'b0001, 1'b1, 1'b0);
    add(4'b0000, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requester 2 sends 6 beats without last (MAX_BEATS=4) while requester 3 waits.
    add(4'b1100, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) add(4'b1100, 4'h0, 1'b0, 4'(k), 4'b0100, 1'b1, 1'b0);
    add(4'b1100, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b1);
    add(4'b1100, 4'b1000, 1'b0, 4'h1, 4'b1000, 1'b1, 1'b0);
    add(4'b0100, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b0100, 4'h0,    1'b0, 4'h5, 4'b0100, 1'b1, 1'b0);
    add(4'b0100, 4'b0100, 1'b0, 4'h6, 4'b0100, 1'b1, 1'b0);
    add(4'b0000, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requester 1 (ptr=3) starts a 3-beat packet; reset lands during beat 3.
    add(4'b0010, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b0010, 4'h0,    1'b0, 4'h1, 4'b0010, 1'b1, 1'b0);
    add(4'b0010, 4'h0,    1'b0, 4'h2, 4'b0010, 1'b1, 1'b0);
    split = vecs.size();
    // After reset ptr must be 0 again, so requester 0 wins over all.
    add(4'hF,    4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'hF,    4'b0001, 1'b0, 4'h1, 4'b0001, 1'b1, 1'b0);
    add(4'h0,    4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    // Requester 0 stalls 2 cycles mid-packet; requester 3 must wait for its last beat.
    add(4'b0001, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b1001, 4'h0,    1'b0, 4'h1, 4'b0001, 1'b1, 1'b0);
    add(4'b1000, 4'h0,    1'b0, 4'h1, 4'b0001, 1'b0, 1'b0);
    add(4'b1000, 4'h0,    1'b0, 4'h1, 4'b0001, 1'b0, 1'b0);
    add(4'b1001, 4'b0001, 1'b0, 4'h2, 4'b0001, 1'b1, 1'b0);
    add(4'b1000, 4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);
    add(4'b1000, 4'b1000, 1'b0, 4'h1, 4'b1000, 1'b1, 1'b0);
    add(4'h0,    4'h0,    1'b0, 4'h0, 4'b0000, 1'b0, 1'b0);

    rst = 1'b1;
    drive(4'hF, 4'h0, 1'b0, 4'h0);
    #1 rst = 1'b0;
    #11;
    check("rst_gnt",   32'(gnt),       32'(0));
    check("rst_winc",  32'(winc),      32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_busy",  32'(busy),      32'(0));
    check("rst_err",   32'(pkt_err),   32'(0));
    drive(4'h0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < split; i++) apply(vecs[i], i);

    // Mid-packet reset: beat 3 is on the write port, then reset must kill it at once.
    @(negedge clk);
    drive(4'b0010, 4'h0, 1'b0, 4'h3);
    #1;
    check("pre_rst_winc",  32'(winc),  32'(1));
    check("pre_rst_wdata", 32'(wdata), 32'(8'hA3));
    #1 rst = 1'b0;
    #1;
    check("mid_rst_gnt",   32'(gnt),       32'(0));
    check("mid_rst_winc",  32'(winc),      32'(0));
    check("mid_rst_ready", 32'(req_ready), 32'(0));
    check("mid_rst_busy",  32'(busy),      32'(0));
    drive(4'h0, 4'h0, 1'b0, 4'h0);
    @(negedge clk);
    check("mid_rst_hold_busy", 32'(busy), 32'(0));
    rst = 1'b1;

    for (int i = split; i < vecs.size(); i++) apply(vecs[i], i);

    check("sb_drain", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
